seed_io_ctrl: RTL and testbench
===============================

SEED_IO_CTRL -- requirements
Module: seed_io_ctrl

Interface
REQ-001 The block SHALL be parameterised as follows, one per line: name, default, meaning.
- ROUND_CYCLES, 24, clock cycles per SEED round in the byte-serial loop.
- NUM_ROUNDS, 16, rounds per block.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, 128-bit input block offered.
- in_ready, out, 1, block can accept input.
- in_data, in, 128, input block; byte 0 = in_data[127:120].
- out_valid, out, 1, result block available.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, 128, result block; byte 0 = out_data[127:120].
- lr_out, out, 8, byte stream to the round datapath LR0 input.
- lr_in, in, 8, byte stream returned from the round datapath LR1 output.
- main_counter, out, 5, byte phase within the current round.
- round_idx, out, 4, current round number, sent to the subkey source.
- busy, out, 1, high in every state except IDLE.
REQ-003 There SHALL be one clock (clk) and one reset (reset_n); reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, RUN, CAP and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-006 In IDLE, in_valid=1 SHALL cause acceptance on the clock edge. At that edge: in_data latches into an internal buffer, the state goes to RUN, and main_counter=0, round_idx=0.
REQ-007 In RUN, main_counter SHALL increment every cycle and wrap from ROUND_CYCLES-1 to 0; round_idx SHALL increment on each wrap.
REQ-008 In RUN, while round_idx=0 and main_counter<16, lr_out SHALL equal buffered byte main_counter; otherwise in RUN, lr_out SHALL equal lr_in (combinational feedback).
REQ-009 The edge at which round_idx=NUM_ROUNDS-1 and main_counter=ROUND_CYCLES-1 SHALL end RUN: the state goes to CAP and the capture count becomes 0.
REQ-010 CAP SHALL last exactly 16 cycles. Each cycle it shifts lr_in into out_data, so that the first captured byte ends in out_data[127:120]. It SHALL then move to DONE.
REQ-011 Latency: with default parameters, out_valid SHALL rise 400 cycles after the accept edge (384 RUN + 16 CAP).
REQ-012 DONE SHALL hold out_valid and a stable out_data until out_valid and out_ready are both 1. The state then returns to IDLE; in_ready rises on the next cycle, with no same-cycle bypass.
REQ-013 in_valid during RUN, CAP or DONE SHALL be ignored; no data is latched.
REQ-014 In IDLE, CAP and DONE, lr_out SHALL be 0, main_counter 0 and round_idx 0.
REQ-015 out_data SHALL change only during CAP.

Reset
REQ-016 Asserting reset_n low SHALL asynchronously force, in any state including mid-RUN or mid-CAP:
- state = IDLE;
- main_counter, round_idx, lr_out = 0;
- out_data and the input buffer = 0;
- out_valid, busy = 0 and in_ready = 1.
REQ-017 After reset_n is released, the first block SHALL be acceptable on the first rising edge.

Configuration
REQ-018 When macro SEED_CTRL_ABORT_EN is defined, the block SHALL add a 1-bit input port abort.
REQ-019 With SEED_CTRL_ABORT_EN defined, abort=1 on a clock edge SHALL force, from any state, a synchronous return to IDLE with the REQ-016 values.
REQ-020 Abort SHALL take priority over acceptance in IDLE and over the out_ready handshake in DONE.
REQ-021 Without SEED_CTRL_ABORT_EN, the abort port SHALL not exist and behaviour SHALL be exactly REQ-004 to REQ-017.

Verification
REQ-022 The bench SHALL cover these directed scenarios.
- Load stream: in_data=0x000102030405060708090A0B0C0D0E0F, in_valid pulsed in IDLE -> lr_out = 0x00..0x0F on the 16 cycles after acceptance, then lr_out tracks lr_in.
- Latency and capture: lr_in tied to the captured-byte index pattern 0xF0+k during CAP -> out_valid at cycle 400 and out_data=0xF0F1...FF.
- Backpressure: out_ready held 0 for 50 cycles in DONE -> out_valid and out_data stable; out_ready=1 -> IDLE, in_ready=1 one cycle later.
- Counters: during RUN, main_counter wraps 23->0 and round_idx steps 0..15; round_idx=15 at main_counter=23 -> CAP next cycle.
- Reset mid-RUN: reset_n pulsed low at cycle 200 -> all outputs at REQ-016 values immediately; a new block then completes in 400 cycles.
- Abort (macro defined): abort=1 at cycle 390 (in CAP) -> IDLE next edge, out_valid never rises.

Source files
------------

// File: rtl/seed_io_ctrl.sv
// seed_io_ctrl: byte-serial SEED block sequencer; loads a block into the round loop, runs NUM_ROUNDS rounds, captures 16 result bytes.
// Latency: out_valid rises NUM_ROUNDS*ROUND_CYCLES+16 cycles after the accept edge; one block in flight, in_ready only in IDLE.
// Backpressure: DONE holds out_valid/out_data until out_ready. Defining SEED_CTRL_ABORT_EN adds a synchronous abort input.
module seed_io_ctrl #(
  parameter int ROUND_CYCLES = 24,
  parameter int NUM_ROUNDS   = 16
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef SEED_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [7:0]   lr_out,
  input  logic [7:0]   lr_in,
  output logic [4:0]   main_counter,
  output logic [3:0]   round_idx,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] MC_LAST = 5'(ROUND_CYCLES - 1);
  localparam logic [3:0] RI_LAST = 4'(NUM_ROUNDS - 1);

  logic [1:0]   state;
  logic [3:0]   cap_cnt;
  logic [127:0] blk_buf;
  logic         abort_int;

`ifdef SEED_CTRL_ABORT_EN
  assign abort_int = abort;
`else
  assign abort_int = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      main_counter <= '0;
      round_idx    <= '0;
      cap_cnt      <= '0;
      blk_buf      <= '0;
      out_data     <= '0;
    end else if (abort_int) begin
      state        <= IDLE;
      main_counter <= '0;
      round_idx    <= '0;
      cap_cnt      <= '0;
      blk_buf      <= '0;
      out_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            blk_buf      <= in_data;
            state        <= RUN;
            main_counter <= '0;
            round_idx    <= '0;
          end
        end
        RUN: begin
          if (main_counter == MC_LAST) begin
            main_counter <= '0;
            if (round_idx == RI_LAST) begin
              // Counters return to 0 so CAP/DONE present idle values downstream.
              round_idx <= '0;
              cap_cnt   <= '0;
              state     <= CAP;
            end else begin
              round_idx <= round_idx + 4'd1;
            end
          end else begin
            main_counter <= main_counter + 5'd1;
          end
        end
        CAP: begin
          out_data <= {out_data[119:0], lr_in};
          cap_cnt  <= cap_cnt + 4'd1;
          if (cap_cnt == 4'd15) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // First 16 cycles of round 0 inject the loaded block, byte 0 first; afterwards the loop is closed.
  always_comb begin
    lr_out = 8'h00;
    if (state == RUN) begin
      if (round_idx == 4'd0 && main_counter < 5'd16)
        lr_out = blk_buf[{~main_counter[3:0], 3'b000} +: 8];
      else
        lr_out = lr_in;
    end
  end

endmodule

// File: tb/tb_seed_io_ctrl.sv
// Scoreboard bench for seed_io_ctrl: driver pushes expected results, negedge monitor compares against a cycle-count model.
module tb_seed_io_ctrl;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [7:0]   lr_out;
  logic [7:0]   lr_in = '0;
  logic [4:0]   main_counter;
  logic [3:0]   round_idx;
  logic         busy;
`ifdef SEED_CTRL_ABORT_EN
  logic         abort = 1'b0;
`endif

  always #5 clk = ~clk;

  seed_io_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef SEED_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .lr_out(lr_out),
    .lr_in(lr_in),
    .main_counter(main_counter),
    .round_idx(round_idx),
    .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: 'active' while a block is in flight, n = clock edges since its accept edge.
  bit           active = 1'b0;
  int           n = 0;
  logic [127:0] cur_in = '0;
  logic [127:0] exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [7:0] exp_lr;
    int e_mc;
    int e_ri;
    chk("in_ready", in_ready, !active);
    chk("busy", busy, active);
    chk("out_valid", out_valid, active && n >= 400);
    e_mc = (active && n < 384) ? n % 24 : 0;
    e_ri = (active && n < 384) ? n / 24 : 0;
    chk("main_counter", main_counter, e_mc);
    chk("round_idx", round_idx, e_ri);
    if (active && n < 16) exp_lr = cur_in[127 - 8*n -: 8];
    else if (active && n < 384) exp_lr = lr_in;
    else exp_lr = 8'h00;
    chk("lr_out", lr_out, exp_lr);
    if (active && n >= 400) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: result present with no expected entry at %0t", $time);
      end else begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // kind: 0 = complete normally, 1 = reset pulse at cycle kill_at, 2 = abort at cycle kill_at
  task automatic run_block(input logic [127:0] din, input int bp, input bit directed,
                           input int kind, input int kill_at);
    logic [7:0]   cap[16];
    logic [127:0] exp;
    int g;
    exp = '0;
    for (int k = 0; k < 16; k++) begin
      cap[k] = directed ? 8'(8'hF0 + k) : 8'($urandom);
      exp = {exp[119:0], cap[k]};
    end
    exp_q.push_back(exp);
    g = 0;
    while (!in_ready && g < 8) begin
      tick();
      g++;
    end
    chk("ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = din;
    tick();
    active = 1'b1;
    n      = 0;
    cur_in = din;
    forever begin
      if (kind == 1 && n == kill_at) begin
        reset_n   = 1'b0;
        active    = 1'b0;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_lr_out", lr_out, 8'h00);
        chk("rst_main_counter", main_counter, 5'd0);
        chk("rst_round_idx", round_idx, 4'd0);
        chk("rst_out_data", out_data, 128'd0);
        #6;
        reset_n = 1'b1;
        return;
      end
`ifdef SEED_CTRL_ABORT_EN
      if (kind == 2 && n == kill_at) begin
        abort = 1'b1;
        tick();
        abort    = 1'b0;
        active   = 1'b0;
        n        = 0;
        in_valid = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_out_data", out_data, 128'd0);
        chk("abort_in_ready", in_ready, 1'b1);
        return;
      end
`endif
      lr_in     = (n >= 384 && n < 400) ? cap[n - 384] : 8'($urandom);
      out_ready = (n >= 400 + bp);
      in_valid  = (n < 400 + bp) ? 1'($urandom) : 1'b0;
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (n >= 400 + bp) begin
        active    = 1'b0;
        n         = 0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        break;
      end
      n++;
    end
  endtask

  initial begin
    #3;
    chk("reset_out_data", out_data, 128'd0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_lr_out", lr_out, 8'h00);
    #9;
    reset_n = 1'b1;
    run_block(128'h000102030405060708090A0B0C0D0E0F, 50, 1'b1, 0, 0);
    tick();
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 0, 0);
    run_block({$urandom, $urandom, $urandom, $urandom}, 3, 1'b0, 1, 200);
    run_block({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 5)), 1'b0, 0, 0);
`ifdef SEED_CTRL_ABORT_EN
    run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, 2, 390);
    tick();
    run_block({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, 0, 0);
`endif
    tick();
    tick();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
